// File: rtl/score_accumulator.sv
// score_accumulator
//   Receives per-player score pulses from the points counter and keeps two
//   3-digit BCD scores and a high score. It also serves one BCD digit per
//   clock to the score video generator. All state lives in the CLK_DRV domain.
//
// Ports
//   CLK_DRV     in   1   drive clock, all state changes on its rising edge
//   RESET_N     in   1   asynchronous active-low reset
//   COUNT_1/2   in   1   player score pulses (level, one count per rising edge)
//   START_GAME  in   1   synchronous clear of scores, wrap and bonus flags
//   GAME_OVER   in   1   rising edge commits max(high, P1, P2) to HIGH_SCORE
//   ATTRACT_N   in   1   low = attract mode, score pulses ignored
//   PLAYER_SEL  in   1   readout player (0 = P1, 1 = P2)
//   DIGIT_SEL   in   2   0 units, 1 tens, 2 hundreds, 3 high-score hundreds
//   DIGIT       out  4   registered readout digit (1-cycle latency)
//   SCORE_1/2   out  12  BCD scores {hundreds, tens, units}
//   HIGH_SCORE  out  12  BCD high score
//   WRAP_1/2    out  1   sticky, score wrapped past the top this game
//   BONUS_1/2   out  1   one-cycle pulse when the score first reaches BONUS_AT
module score_accumulator #(
  parameter logic [11:0] BONUS_AT     = 12'h000,
  parameter int unsigned HUNDREDS_MAX = 9
) (
  input  logic        CLK_DRV,
  input  logic        RESET_N,
  input  logic        COUNT_1,
  input  logic        COUNT_2,
  input  logic        START_GAME,
  input  logic        GAME_OVER,
  input  logic        ATTRACT_N,
  input  logic        PLAYER_SEL,
  input  logic [1:0]  DIGIT_SEL,
  output logic [3:0]  DIGIT,
  output logic [11:0] SCORE_1,
  output logic [11:0] SCORE_2,
  output logic [11:0] HIGH_SCORE,
  output logic        WRAP_1,
  output logic        WRAP_2,
  output logic        BONUS_1,
  output logic        BONUS_2
);

  localparam logic [3:0] HMAX = 4'(HUNDREDS_MAX);

  // BCD +1. Returns {wrap, hundreds, tens, units}.
  function automatic logic [12:0] bcd_inc(input logic [11:0] s);
    logic [3:0] u;
    logic [3:0] t;
    logic [3:0] h;
    logic       w;
    u = s[3:0];
    t = s[7:4];
    h = s[11:8];
    w = 1'b0;
    if (u == 4'd9) begin
      u = 4'd0;
      if (t == 4'd9) begin
        t = 4'd0;
        // >= rather than == so that no out-of-range hundreds digit can survive
        if (h >= HMAX) begin
          h = 4'd0;
          w = 1'b1;
        end else begin
          h = h + 4'd1;
        end
      end else begin
        t = t + 4'd1;
      end
    end else begin
      u = u + 4'd1;
    end
    return {w, h, t, u};
  endfunction

  // Per-player state is indexed 0 = P1, 1 = P2.
  logic [1:0]        cnt_in;
  logic [1:0]        cnt_q;
  logic [1:0]        inc;
  logic [1:0][12:0]  inc_val;
  logic [1:0][11:0]  score_q;
  logic [1:0][11:0]  score_d;
  logic [1:0]        wrap_q;
  logic [1:0]        wrap_d;
  logic [1:0]        armed_q;
  logic [1:0]        armed_d;
  logic [1:0]        bonus_q;
  logic [1:0]        bonus_d;
  logic              go_q;
  logic [11:0]       high_q;
  logic [11:0]       high_d;
  logic [11:0]       best;
  logic [3:0]        digit_q;
  logic [3:0]        digit_d;
  logic [11:0]       sel_score;

  assign cnt_in = {COUNT_2, COUNT_1};

  // Edge detect: one increment per rising edge regardless of pulse width.
  assign inc = cnt_in & ~cnt_q & {2{ATTRACT_N}};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_inc
      assign inc_val[gi] = bcd_inc(score_q[gi]);
    end
  endgenerate

  always_comb begin
    score_d = score_q;
    wrap_d  = wrap_q;
    armed_d = armed_q;
    bonus_d = 2'b00;
    for (int p = 0; p < 2; p++) begin
      if (START_GAME) begin
        // Clear has priority; edges landing in this cycle are dropped.
        score_d[p] = 12'h000;
        wrap_d[p]  = 1'b0;
        armed_d[p] = 1'b1;
      end else if (inc[p]) begin
        score_d[p] = inc_val[p][11:0];
        if (inc_val[p][12]) begin
          wrap_d[p] = 1'b1;
        end
        // BCD ordering matches binary ordering of the packed vector.
        if (armed_q[p] && (BONUS_AT != 12'h000) &&
            (inc_val[p][11:0] >= BONUS_AT)) begin
          bonus_d[p] = 1'b1;
          armed_d[p] = 1'b0;
        end
      end
    end
  end

  // High-score compare uses the pre-increment / pre-clear score values.
  always_comb begin
    best = high_q;
    if (score_q[0] > best) begin
      best = score_q[0];
    end
    if (score_q[1] > best) begin
      best = score_q[1];
    end
    high_d = high_q;
    if (GAME_OVER && !go_q) begin
      high_d = best;
    end
  end

  assign sel_score = PLAYER_SEL ? score_q[1] : score_q[0];

  always_comb begin
    digit_d = 4'd0;
    case (DIGIT_SEL)
      2'd0:    digit_d = sel_score[3:0];
      2'd1:    digit_d = sel_score[7:4];
      2'd2:    digit_d = sel_score[11:8];
      default: digit_d = high_q[11:8];
    endcase
  end

  // Bonus flags come out of reset disarmed; the first START_GAME arms them.
  always_ff @(posedge CLK_DRV or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q   <= 2'b00;
      score_q <= '0;
      wrap_q  <= 2'b00;
      armed_q <= 2'b00;
      bonus_q <= 2'b00;
      go_q    <= 1'b0;
      high_q  <= 12'h000;
      digit_q <= 4'd0;
    end else begin
      cnt_q   <= cnt_in;
      score_q <= score_d;
      wrap_q  <= wrap_d;
      armed_q <= armed_d;
      bonus_q <= bonus_d;
      go_q    <= GAME_OVER;
      high_q  <= high_d;
      digit_q <= digit_d;
    end
  end

  assign DIGIT      = digit_q;
  assign SCORE_1    = score_q[0];
  assign SCORE_2    = score_q[1];
  assign HIGH_SCORE = high_q;
  assign WRAP_1     = wrap_q[0];
  assign WRAP_2     = wrap_q[1];
  assign BONUS_1    = bonus_q[0];
  assign BONUS_2    = bonus_q[1];

endmodule

// File: tb/tb_score_accumulator.sv
// Directed bench for score_accumulator with BONUS_AT = 100.
// Inputs change on the falling clock edge and outputs are sampled there.
module tb_score_accumulator;

  logic        CLK_DRV;
  logic        RESET_N;
  logic        COUNT_1;
  logic        COUNT_2;
  logic        START_GAME;
  logic        GAME_OVER;
  logic        ATTRACT_N;
  logic        PLAYER_SEL;
  logic [1:0]  DIGIT_SEL;
  logic [3:0]  DIGIT;
  logic [11:0] SCORE_1;
  logic [11:0] SCORE_2;
  logic [11:0] HIGH_SCORE;
  logic        WRAP_1;
  logic        WRAP_2;
  logic        BONUS_1;
  logic        BONUS_2;

  int n_checks = 0;
  int n_fail   = 0;
  int b1_cnt   = 0;
  int b2_cnt   = 0;

  typedef struct {
    logic       psel;
    logic [1:0] dsel;
    logic [3:0] exp_digit;
  } rd_vec_t;

  rd_vec_t tbl_a [8];
  rd_vec_t tbl_b [4];

  score_accumulator #(
    .BONUS_AT    (12'h100),
    .HUNDREDS_MAX(9)
  ) dut (
    .CLK_DRV   (CLK_DRV),
    .RESET_N   (RESET_N),
    .COUNT_1   (COUNT_1),
    .COUNT_2   (COUNT_2),
    .START_GAME(START_GAME),
    .GAME_OVER (GAME_OVER),
    .ATTRACT_N (ATTRACT_N),
    .PLAYER_SEL(PLAYER_SEL),
    .DIGIT_SEL (DIGIT_SEL),
    .DIGIT     (DIGIT),
    .SCORE_1   (SCORE_1),
    .SCORE_2   (SCORE_2),
    .HIGH_SCORE(HIGH_SCORE),
    .WRAP_1    (WRAP_1),
    .WRAP_2    (WRAP_2),
    .BONUS_1   (BONUS_1),
    .BONUS_2   (BONUS_2)
  );

  initial CLK_DRV = 1'b0;
  always #5 CLK_DRV = ~CLK_DRV;

  // Count the number of cycles each bonus output is seen high.
  always @(negedge CLK_DRV) begin
    if (BONUS_1 === 1'b1) b1_cnt++;
    if (BONUS_2 === 1'b1) b2_cnt++;
  end

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // n pulses, each one cycle high then one cycle low; starts and ends on a falling edge.
  task automatic pulse(input logic p1, input logic p2, input int n);
    for (int i = 0; i < n; i++) begin
      COUNT_1 = p1;
      COUNT_2 = p2;
      @(negedge CLK_DRV);
      COUNT_1 = 1'b0;
      COUNT_2 = 1'b0;
      @(negedge CLK_DRV);
    end
  endtask

  task automatic start_game();
    START_GAME = 1'b1;
    @(negedge CLK_DRV);
    START_GAME = 1'b0;
  endtask

  task automatic run_readout(input rd_vec_t v, input string name);
    PLAYER_SEL = v.psel;
    DIGIT_SEL  = v.dsel;
    @(negedge CLK_DRV);
    check(name, 12'(DIGIT), 12'(v.exp_digit));
  endtask

  initial begin
    int b1_base;

    // Readout vectors once P1 = 012, P2 = 003, high = 000.
    tbl_a[0] = '{1'b0, 2'd0, 4'd2};
    tbl_a[1] = '{1'b0, 2'd1, 4'd1};
    tbl_a[2] = '{1'b0, 2'd2, 4'd0};
    tbl_a[3] = '{1'b1, 2'd0, 4'd3};
    tbl_a[4] = '{1'b1, 2'd1, 4'd0};
    tbl_a[5] = '{1'b1, 2'd2, 4'd0};
    tbl_a[6] = '{1'b0, 2'd3, 4'd0};
    tbl_a[7] = '{1'b1, 2'd3, 4'd0};
    // Readout vectors once P1 = 000, P2 = 000, high = 310.
    tbl_b[0] = '{1'b0, 2'd3, 4'd3};
    tbl_b[1] = '{1'b1, 2'd3, 4'd3};
    tbl_b[2] = '{1'b1, 2'd2, 4'd0};
    tbl_b[3] = '{1'b0, 2'd0, 4'd0};

    RESET_N    = 1'b1;
    COUNT_1    = 1'b0;
    COUNT_2    = 1'b0;
    START_GAME = 1'b0;
    GAME_OVER  = 1'b0;
    ATTRACT_N  = 1'b1;
    PLAYER_SEL = 1'b0;
    DIGIT_SEL  = 2'd0;
    #2 RESET_N = 1'b0;
    repeat (2) @(negedge CLK_DRV);
    check("reset score_1", SCORE_1, 12'h000);
    check("reset score_2", SCORE_2, 12'h000);
    check("reset high", HIGH_SCORE, 12'h000);
    check("reset digit", 12'(DIGIT), 12'h000);
    check("reset wrap/bonus", 12'({WRAP_1, WRAP_2, BONUS_1, BONUS_2}), 12'h000);
    RESET_N = 1'b1;
    @(negedge CLK_DRV);

    // 12 single-cycle P1 pulses.
    pulse(1'b1, 1'b0, 12);
    check("p1 x12 score_1", SCORE_1, 12'h012);
    check("p1 x12 score_2", SCORE_2, 12'h000);
    PLAYER_SEL = 1'b0;
    DIGIT_SEL  = 2'd1;
    @(negedge CLK_DRV);
    check("p1 tens digit", 12'(DIGIT), 12'h001);

    // COUNT_2 held five cycles per pulse: one count per edge.
    for (int r = 0; r < 3; r++) begin
      COUNT_2 = 1'b1;
      repeat (5) @(negedge CLK_DRV);
      COUNT_2 = 1'b0;
      repeat (2) @(negedge CLK_DRV);
    end
    check("p2 wide pulses score_2", SCORE_2, 12'h003);
    check("p2 wide pulses score_1", SCORE_1, 12'h012);

    for (int i = 0; i < 8; i++) run_readout(tbl_a[i], $sformatf("readout_a[%0d]", i));

    // START_GAME with a coinciding edge: edge is dropped, never counted later.
    START_GAME = 1'b1;
    COUNT_1    = 1'b1;
    @(negedge CLK_DRV);
    START_GAME = 1'b0;
    @(negedge CLK_DRV);
    COUNT_1 = 1'b0;
    @(negedge CLK_DRV);
    check("start clears score_1", SCORE_1, 12'h000);
    check("start clears score_2", SCORE_2, 12'h000);
    check("start keeps high", HIGH_SCORE, 12'h000);

    // Preload P1 to 998; bonus should fire once on the way through 100.
    b1_base = b1_cnt;
    pulse(1'b1, 1'b0, 998);
    check("preload score_1", SCORE_1, 12'h998);
    check("preload bonus_1 once", 12'(b1_cnt - b1_base), 12'd1);
    pulse(1'b1, 1'b1, 1);
    check("both edge score_1", SCORE_1, 12'h999);
    pulse(1'b1, 1'b1, 1);
    check("wrap score_1", SCORE_1, 12'h000);
    check("wrap_1 set", 12'(WRAP_1), 12'h001);
    check("both edge score_2", SCORE_2, 12'h002);
    check("wrap_2 clear", 12'(WRAP_2), 12'h000);
    pulse(1'b1, 1'b0, 1);
    check("post wrap score_1", SCORE_1, 12'h001);
    check("wrap_1 sticky", 12'(WRAP_1), 12'h001);
    check("no rearm on wrap", 12'(b1_cnt - b1_base), 12'd1);

    // Bonus boundary at exactly 100.
    start_game();
    check("start clears wrap_1", 12'(WRAP_1), 12'h000);
    b1_base = b1_cnt;
    pulse(1'b1, 1'b0, 99);
    check("bonus pre score_1", SCORE_1, 12'h099);
    check("no bonus below 100", 12'(b1_cnt - b1_base), 12'd0);
    pulse(1'b1, 1'b0, 1);
    check("bonus at 100", 12'(b1_cnt - b1_base), 12'd1);
    pulse(1'b1, 1'b0, 1);
    check("no bonus at 101", 12'(b1_cnt - b1_base), 12'd1);
    check("score_1 101", SCORE_1, 12'h101);
    start_game();
    pulse(1'b1, 1'b0, 100);
    check("bonus rearmed by start", 12'(b1_cnt - b1_base), 12'd2);
    check("no bonus_2 so far", 12'(b2_cnt), 12'd0);

    // High score: 300 first, then P1 = 250 / P2 = 310 with simultaneous GAME_OVER + START_GAME.
    start_game();
    pulse(1'b1, 1'b0, 300);
    GAME_OVER = 1'b1;
    @(negedge CLK_DRV);
    GAME_OVER = 1'b0;
    check("high 300", HIGH_SCORE, 12'h300);
    start_game();
    pulse(1'b1, 1'b1, 250);
    pulse(1'b0, 1'b1, 60);
    check("hs setup score_1", SCORE_1, 12'h250);
    check("hs setup score_2", SCORE_2, 12'h310);
    GAME_OVER  = 1'b1;
    START_GAME = 1'b1;
    @(negedge CLK_DRV);
    START_GAME = 1'b0;
    check("high takes 310", HIGH_SCORE, 12'h310);
    check("go+start score_1", SCORE_1, 12'h000);
    check("go+start score_2", SCORE_2, 12'h000);
    @(negedge CLK_DRV);
    GAME_OVER = 1'b0;
    @(negedge CLK_DRV);
    GAME_OVER = 1'b1;
    @(negedge CLK_DRV);
    GAME_OVER = 1'b0;
    check("high not lowered", HIGH_SCORE, 12'h310);

    for (int i = 0; i < 4; i++) run_readout(tbl_b[i], $sformatf("readout_b[%0d]", i));

    // Readout latency: increment edge in cycle k shows on DIGIT at k+2.
    PLAYER_SEL = 1'b1;
    DIGIT_SEL  = 2'd0;
    @(negedge CLK_DRV);
    COUNT_2 = 1'b1;
    @(negedge CLK_DRV);
    COUNT_2 = 1'b0;
    check("latency score_2", SCORE_2, 12'h001);
    check("latency digit stale", 12'(DIGIT), 12'h000);
    @(negedge CLK_DRV);
    check("latency digit new", 12'(DIGIT), 12'h001);

    // Attract mode ignores pulses.
    start_game();
    ATTRACT_N = 1'b0;
    pulse(1'b1, 1'b0, 20);
    check("attract score_1", SCORE_1, 12'h000);
    ATTRACT_N = 1'b1;
    pulse(1'b1, 1'b0, 5);
    check("after attract score_1", SCORE_1, 12'h005);
    PLAYER_SEL = 1'b0;
    DIGIT_SEL  = 2'd3;
    @(negedge CLK_DRV);
    check("digit high hundreds", 12'(DIGIT), 12'h003);

    // Asynchronous reset in the middle of a pulse, between clock edges.
    COUNT_1 = 1'b1;
    #2 RESET_N = 1'b0;
    #1;
    check("async rst score_1", SCORE_1, 12'h000);
    check("async rst high", HIGH_SCORE, 12'h000);
    check("async rst digit", 12'(DIGIT), 12'h000);
    @(negedge CLK_DRV);
    RESET_N = 1'b1;
    // COUNT_1 is still high at release: counts exactly once.
    @(negedge CLK_DRV);
    check("held through reset counts", SCORE_1, 12'h001);
    @(negedge CLK_DRV);
    check("held counts only once", SCORE_1, 12'h001);
    COUNT_1 = 1'b0;
    @(negedge CLK_DRV);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_accumulator.md
Name: score_accumulator

Overview:
- Receiving end of the score-pulse interface: consumes per-player score clock pulses (COUNT_1, COUNT_2) from the points counter.
- Accumulates two 3-digit BCD player scores and tracks a high score.
- Serves one BCD digit at a time to the score video generator.
- Sits between the points counter and the score display / extra-ball logic, in the CLK_DRV domain.

Parameters:
- BONUS_AT, 12'h000, BCD score at which the one-shot bonus flag fires; 12'h000 disables bonus.
- HUNDREDS_MAX, 9, largest hundreds digit before wrap (3-digit BCD, 999 max).

Ports:
- CLK_DRV  input  1  system drive clock; all state changes on its rising edge
- RESET_N  input  1  asynchronous active-low reset
- COUNT_1  input  1  player-1 score pulse, level, synchronous to CLK_DRV
- COUNT_2  input  1  player-2 score pulse, level, synchronous to CLK_DRV
- START_GAME  input  1  synchronous clear of both player scores and flags
- GAME_OVER  input  1  level; its rising edge commits the high-score compare
- ATTRACT_N  input  1  low = attract mode; score pulses ignored
- PLAYER_SEL  input  1  readout player: 0 = P1, 1 = P2
- DIGIT_SEL  input  2  readout digit: 0 = units, 1 = tens, 2 = hundreds, 3 = high-score hundreds
- DIGIT  output  4  registered BCD digit for the selected player/position
- SCORE_1  output  12  P1 BCD score {hundreds, tens, units}
- SCORE_2  output  12  P2 BCD score
- HIGH_SCORE  output  12  BCD high score
- WRAP_1, WRAP_2  output  1  sticky: score wrapped 999→000 this game
- BONUS_1, BONUS_2  output  1  single-cycle pulse when the score first reaches or passes BONUS_AT this game

Behaviour:
- Reset (RESET_N low, asynchronous): all scores, HIGH_SCORE, DIGIT, WRAP_*, BONUS_*, bonus-armed flags, and edge-detect registers go to 0. Edge-detect registers are cleared to 0, so a pulse held high through reset release counts once.
- Edge detect:
  - Registered copies c1q and c2q of COUNT_1 and COUNT_2.
  - inc_n = COUNT_n & ~cnq & ATTRACT_N.
  - Exactly one increment per rising edge, regardless of pulse width.
- Increment:
  - Score += 1 in BCD. Units 9→0 carries to tens; tens 9→0 carries to hundreds.
  - Hundreds at HUNDREDS_MAX with carry → 000, and WRAP_n is set (sticky).
  - Score registers never hold a non-BCD nibble.
- Simultaneous COUNT_1 and COUNT_2 edges: both players increment in the same cycle, independently.
- START_GAME high (priority over increment):
  - SCORE_1, SCORE_2, WRAP_*, BONUS_* are cleared and both bonus flags are re-armed.
  - Edges coinciding with START_GAME are discarded.
  - HIGH_SCORE is unchanged.
- Bonus:
  - Condition: armed_n and BONUS_AT ≠ 0 and the next score value ≥ BONUS_AT (BCD compare, equal to binary compare of the 12-bit vector).
  - When the condition holds on an increment: BONUS_n is high for one cycle and armed_n clears.
  - Wrap does not re-arm; only START_GAME or reset re-arms.
- High score:
  - On a rising edge of GAME_OVER (registered edge detect): HIGH_SCORE ← max(HIGH_SCORE, SCORE_1, SCORE_2).
  - The compare uses the score values before any same-cycle increment.
  - If GAME_OVER and START_GAME rise together, the compare is taken first, then the scores clear.
- Readout:
  - DIGIT is registered with 1-cycle latency from PLAYER_SEL/DIGIT_SEL.
  - DIGIT_SEL = 3 returns HIGH_SCORE[11:8] regardless of PLAYER_SEL.
  - Readout reflects the score value as of the previous clock; an increment in cycle k is visible on DIGIT at k+2 when the select is held.
- ATTRACT_N low: no increments or bonus pulses; readout, START_GAME, and GAME_OVER still operate.

Test Plan:
- Reset then 12 single-cycle COUNT_1 pulses with ATTRACT_N=1 → SCORE_1=12'h012, SCORE_2=0; PLAYER_SEL=0, DIGIT_SEL=1 → DIGIT=1 after one clock.
- COUNT_2 held high for 5 cycles, then low, repeated 3× → SCORE_2=12'h003 (one count per edge, not per cycle).
- Preload P1 to 998, then COUNT_1 and COUNT_2 edges in the same cycle twice → SCORE_1=000 with WRAP_1=1; SCORE_2 incremented by 2; WRAP_2=0.
- BONUS_AT=12'h100: drive P1 from 099 to 101 → BONUS_1 high for exactly one cycle on 099→100, no pulse on 101; START_GAME, then 100 more edges → BONUS_1 pulses again.
- SCORE_1=250, SCORE_2=310, HIGH_SCORE=300; GAME_OVER and START_GAME rise in the same cycle → HIGH_SCORE=310 and both scores =0 the next cycle.
- ATTRACT_N=0 with 20 COUNT_1 edges → SCORE_1 unchanged; assert RESET_N low mid-pulse → all outputs 0 immediately (asynchronous).
